i2c_master_ctrl: RTL and testbench
==================================

// Module: i2c_master_ctrl
// PURPOSE
//  Synthesizable byte-level I2C initiator; the bus-driving counterpart of the i2c_if slave BFM.
//  Host issues START/STOP/WRITE/READ commands over a valid/ready port; block generates SCL/SDA
//  through open-drain enables and returns the byte read, ACK status and error flag per command.
//  Sits between the command layer and the tri-state pads of scl_i2c/sda_i2c.
// PARAMETERS
//  CLK_DIV        16  clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV); legal >= 2
//  I2C_DATA_WIDTH 8   bits per data byte
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous reset, active low
//  cmd_valid  in   1  command present
//  cmd_ready  out  1  block can accept a command
//  cmd_op     in   3  0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NAK, 5-7 illegal
//  cmd_data   in   8  byte for WRITE (bit 7 sent first)
//  rsp_valid  out  1  one-cycle pulse: command complete
//  rsp_data   out  8  byte received (READ_*); holds last value otherwise
//  rsp_nak    out  1  WRITE: SDA level sampled in 9th bit (1 = NAK)
//  rsp_err    out  1  command rejected, no bus activity
//  busy       out  1  command in progress
//  bus_held   out  1  START issued, STOP not yet issued
//  scl_i      in   1  sampled SCL line
//  sda_i      in   1  sampled SDA line
//  scl_oe     out  1  1 = drive SCL low, 0 = release
//  sda_oe     out  1  1 = drive SDA low, 0 = release
// BEHAVIOUR
//  - Reset (async): scl_oe=sda_oe=0, cmd_ready=1, busy=0, bus_held=0, rsp_valid=0, rsp_data=0,
//    rsp_nak=0, rsp_err=0, FSM=IDLE, counters=0. Asserting reset mid-command releases both lines at once.
//  - Handshake: accept on cmd_valid&&cmd_ready; cmd_ready=0, busy=1 from the next cycle until the
//    rsp_valid cycle. Commands presented while cmd_ready=0 are ignored.
//  - Quarter timer counts 0..CLK_DIV-1; phase Q0..Q3 advances on terminal count.
//  - START (legal anytime): Q0 release SDA; Q1 release SCL; Q2 drive SDA low; Q3 drive SCL low.
//    Covers idle and repeated start. Sets bus_held.
//  - STOP (requires bus_held): Q0 drive SDA low; Q1 release SCL; Q2 release SDA; Q3 hold.
//    Clears bus_held; ends with scl_oe=sda_oe=0.
//  - Bit slot: Q0 SCL low, SDA updated; Q1,Q2 SCL released; sda_i sampled on last clk of Q2;
//    Q3 SCL driven low. SDA never changes while SCL released except in START/STOP.
//  - WRITE: 8 slots MSB first (sda_oe = ~bit), 9th slot SDA released, rsp_nak = sample.
//  - READ_ACK/READ_NAK: 8 slots SDA released, shift samples MSB first into rsp_data; 9th slot
//    drive SDA low (ACK) or release (NAK). rsp_nak=0.
//  - Latency accept->rsp_valid: START/STOP 4*CLK_DIV+1; byte commands 36*CLK_DIV+1 clk cycles.
//  - Errors: WRITE/READ_*/STOP with bus_held=0, or cmd_op 5-7 -> rsp_valid+rsp_err=1 two cycles
//    after accept, lines unchanged. rsp_err cleared on next accept.
//  - FSM: IDLE -> START_SEQ | STOP_SEQ | DATA_BITS -> ACK_BIT -> RESP -> IDLE; ERR -> RESP.
//  - Between commands with bus_held=1 SCL stays driven low (bus parked).
// CONFIGURATION
//  I2C_MASTER_CLOCK_STRETCH_EN defined: in every phase where SCL is released (START Q1, STOP Q1,
//    bit Q1), the quarter timer holds at 0 until scl_i==1, then counts; slave stretching lengthens
//    the command by the stretch time. Undefined: scl_i ignored, fixed timing.
// TESTING (slave BFM at address 0x22, CLK_DIV=4)
//  - START, WRITE 0x44, WRITE 0xA5, STOP -> rsp_nak=0 twice; BFM op=WRITE, data={0xA5}, stop_flag=1.
//  - START, WRITE 0x45, READ_ACK, READ_NAK, STOP with BFM data {0x5A,0xC3} -> rsp_data 0x5A
//    then 0xC3; 9th-bit SDA low then released.
//  - START, WRITE 0x90 (no slave) -> rsp_nak=1; WRITE byte latency exactly 145 clk.
//  - WRITE 0x11 after reset (no START) -> rsp_err=1 at accept+2, scl_oe/sda_oe stay 0.
//  - START, WRITE 0x44, WRITE 0x01, START, WRITE 0x45, READ_NAK -> BFM sees repeated start,
//    then read; bus_held stays 1 until STOP.
//  - Slave holds SCL low 50 clk in bit 3 -> with macro byte latency 195 clk, without 145;
//    rst_n low mid-byte -> scl_oe=sda_oe=0 same cycle, cmd_ready=1.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C initiator: START/STOP/WRITE/READ commands in, open-drain SCL/SDA enables out.
// Optional macro I2C_MASTER_CLOCK_STRETCH_EN: honour slave clock stretching in SCL-released phases.
module i2c_master_ctrl #(
    parameter int CLK_DIV        = 16,
    parameter int I2C_DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [I2C_DATA_WIDTH-1:0] cmd_data,
    output logic                      rsp_valid,
    output logic [I2C_DATA_WIDTH-1:0] rsp_data,
    output logic                      rsp_nak,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      bus_held,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_oe,
    output logic                      sda_oe
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(I2C_DATA_WIDTH);
    localparam int W  = I2C_DATA_WIDTH;

    localparam logic [2:0] OP_START    = 3'd0;
    localparam logic [2:0] OP_STOP     = 3'd1;
    localparam logic [2:0] OP_WRITE    = 3'd2;
    localparam logic [2:0] OP_READ_ACK = 3'd3;
    localparam logic [2:0] OP_READ_NAK = 3'd4;

    typedef enum logic [2:0] {
        IDLE, START_SEQ, STOP_SEQ, DATA_BITS, ACK_BIT, ERR, RESP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      phase_q, phase_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    shift_q, shift_d;
    logic            nak_q, nak_d;
    logic            err_q, err_d;
    logic            bus_held_q, bus_held_d;
    logic            sda_park_q, sda_park_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            rsp_nak_q, rsp_nak_d;
    logic            rsp_err_q, rsp_err_d;

    logic timer_tc, rd_op, stall, illegal;

    assign timer_tc  = (timer_q == TW'(CLK_DIV - 1));
    assign rd_op     = (op_q == OP_READ_ACK) || (op_q == OP_READ_NAK);
    assign illegal   = (cmd_op > OP_READ_NAK) || ((cmd_op != OP_START) && !bus_held_q);
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign bus_held  = bus_held_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_nak   = rsp_nak_q;
    assign rsp_err   = rsp_err_q;

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
    // Q1 is the quarter in which SCL is released in every bus sequence.
    assign stall = (phase_q == 2'd1) && (timer_q == '0) && !scl_i &&
                   ((state_q == START_SEQ) || (state_q == STOP_SEQ) ||
                    (state_q == DATA_BITS) || (state_q == ACK_BIT));
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign stall        = 1'b0;
`endif

    // Line drive; outside bus sequences the bus stays parked at its last level.
    always_comb begin
        scl_oe = bus_held_q;
        sda_oe = sda_park_q;
        unique case (state_q)
            START_SEQ: begin
                scl_oe = (phase_q == 2'd0) ? bus_held_q : (phase_q == 2'd3);
                sda_oe = phase_q[1];
            end
            STOP_SEQ: begin
                scl_oe = (phase_q == 2'd0);
                sda_oe = !phase_q[1];
            end
            DATA_BITS: begin
                scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
                sda_oe = (op_q == OP_WRITE) ? !shift_q[W-1] : 1'b0;
            end
            ACK_BIT: begin
                scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
                sda_oe = (op_q == OP_READ_ACK);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        op_d        = op_q;
        shift_d     = shift_q;
        nak_d       = nak_q;
        err_d       = err_q;
        bus_held_d  = bus_held_q;
        sda_park_d  = sda_park_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_nak_d   = rsp_nak_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rsp_err_d = 1'b0;
                    op_d      = cmd_op;
                    err_d     = illegal;
                    timer_d   = '0;
                    phase_d   = 2'd0;
                    bit_cnt_d = '0;
                    shift_d   = (cmd_op == OP_WRITE) ? cmd_data : '0;
                    if (illegal)                state_d = ERR;
                    else if (cmd_op == OP_START) state_d = START_SEQ;
                    else if (cmd_op == OP_STOP)  state_d = STOP_SEQ;
                    else                         state_d = DATA_BITS;
                end
            end
            START_SEQ, STOP_SEQ, DATA_BITS, ACK_BIT: begin
                sda_park_d = sda_oe;
                if (!stall) begin
                    timer_d = timer_tc ? '0 : timer_q + TW'(1);
                    if (timer_tc) phase_d = phase_q + 2'd1;
                end
                if ((phase_q == 2'd2) && timer_tc) begin
                    if ((state_q == DATA_BITS) && rd_op) shift_d = {shift_q[W-2:0], sda_i};
                    if (state_q == ACK_BIT)              nak_d   = sda_i;
                end
                if ((phase_q == 2'd3) && timer_tc) begin
                    unique case (state_q)
                        START_SEQ: begin
                            bus_held_d = 1'b1;
                            state_d    = RESP;
                        end
                        STOP_SEQ: begin
                            bus_held_d = 1'b0;
                            state_d    = RESP;
                        end
                        DATA_BITS: begin
                            if (!rd_op) shift_d = {shift_q[W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + BW'(1);
                            if (bit_cnt_q == BW'(W - 1)) begin
                                bit_cnt_d = '0;
                                state_d   = ACK_BIT;
                            end
                        end
                        default: state_d = RESP;
                    endcase
                end
            end
            ERR: state_d = RESP;
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_nak_d   = !err_q && (op_q == OP_WRITE) && nak_q;
                if (!err_q && rd_op) rsp_data_d = shift_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            phase_q     <= 2'd0;
            bit_cnt_q   <= '0;
            op_q        <= 3'd0;
            shift_q     <= '0;
            nak_q       <= 1'b0;
            err_q       <= 1'b0;
            bus_held_q  <= 1'b0;
            sda_park_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_nak_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            op_q        <= op_d;
            shift_q     <= shift_d;
            nak_q       <= nak_d;
            err_q       <= err_d;
            bus_held_q  <= bus_held_d;
            sda_park_q  <= sda_park_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_nak_q   <= rsp_nak_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a small behavioural I2C slave at address 0x22.
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 4;
`ifdef I2C_MASTER_CLOCK_STRETCH_EN
    localparam int STRETCH_LAT = 195;
`else
    localparam int STRETCH_LAT = 145;
`endif
    localparam logic [2:0] OP_START = 3'd0, OP_STOP = 3'd1, OP_WRITE = 3'd2,
                           OP_READ_ACK = 3'd3, OP_READ_NAK = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_nak, rsp_err, busy, bus_held, scl_oe, sda_oe;
    logic [7:0] rsp_data;
    logic       scl_hold = 1'b0;
    logic       s_sda_low;
    wire        scl_line = ~(scl_oe | scl_hold);
    wire        sda_line = ~(sda_oe | s_sda_low);

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .I2C_DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nak(rsp_nak), .rsp_err(rsp_err),
        .busy(busy), .bus_held(bus_held),
        .scl_i(scl_line), .sda_i(sda_line), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    // Behavioural slave
    logic       prev_scl, prev_sda, s_act, s_fresh, s_addr_ph, s_read, s_match, s_mack, stop_flag;
    logic       rd_idx;
    int         s_bit, wr_cnt, mack_cnt, rep_cnt;
    logic [7:0] s_rx, s_tx;
    logic [7:0] wr_log [4];
    logic       mack_log [4];
    logic [7:0] rd_mem [2];
    initial begin
        rd_mem[0] = 8'h5A;
        rd_mem[1] = 8'hC3;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_scl <= 1'b1; prev_sda <= 1'b1; s_act <= 1'b0; s_fresh <= 1'b0;
            s_addr_ph <= 1'b0; s_read <= 1'b0; s_match <= 1'b0; s_mack <= 1'b1;
            stop_flag <= 1'b0; rd_idx <= 1'b0; s_bit <= 0; wr_cnt <= 0; mack_cnt <= 0;
            rep_cnt <= 0; s_rx <= 8'd0; s_tx <= 8'd0; s_sda_low <= 1'b0;
        end else begin
            prev_scl <= scl_line;
            prev_sda <= sda_line;
            if (scl_line && prev_scl && prev_sda && !sda_line) begin
                if (s_act) rep_cnt <= rep_cnt + 1;
                s_act <= 1'b1; s_fresh <= 1'b1; s_addr_ph <= 1'b1; s_match <= 1'b0;
                s_bit <= 0; s_sda_low <= 1'b0; stop_flag <= 1'b0;
            end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
                stop_flag <= 1'b1; s_act <= 1'b0; s_sda_low <= 1'b0;
            end else if (s_act && !prev_scl && scl_line) begin
                if (s_bit < 8 && (s_addr_ph || !s_read)) s_rx <= {s_rx[6:0], sda_line};
                else if (s_bit == 8 && s_read && !s_addr_ph) begin
                    s_mack <= sda_line;
                    if (mack_cnt < 4) mack_log[mack_cnt] <= sda_line;
                    mack_cnt <= mack_cnt + 1;
                end
            end else if (s_act && prev_scl && !scl_line) begin
                if (s_fresh) s_fresh <= 1'b0;
                else begin
                    s_bit <= (s_bit == 8) ? 0 : s_bit + 1;
                    if (s_bit == 7) begin
                        if (s_addr_ph) begin
                            s_match   <= (s_rx[7:1] == 7'h22);
                            s_read    <= s_rx[0];
                            s_sda_low <= (s_rx[7:1] == 7'h22);
                        end else if (!s_read) begin
                            if (wr_cnt < 4) wr_log[wr_cnt] <= s_rx;
                            wr_cnt    <= wr_cnt + 1;
                            s_sda_low <= 1'b1;
                        end else s_sda_low <= 1'b0;
                    end else if (s_bit == 8) begin
                        if (s_addr_ph) begin
                            s_addr_ph <= 1'b0;
                            if (!s_match) begin
                                s_act <= 1'b0; s_sda_low <= 1'b0;
                            end else if (s_read) begin
                                rd_idx <= 1'b0; s_tx <= rd_mem[0]; s_sda_low <= ~rd_mem[0][7];
                            end else s_sda_low <= 1'b0;
                        end else if (s_read && !s_mack) begin
                            rd_idx    <= ~rd_idx;
                            s_tx      <= rd_mem[~rd_idx];
                            s_sda_low <= ~rd_mem[~rd_idx][7];
                        end else s_sda_low <= 1'b0;
                    end else if (s_read && !s_addr_ph) s_sda_low <= ~s_tx[6-s_bit];
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command from a posedge+1 point; returns accept->rsp_valid latency.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] data, input int hold_at,
                          output int lat);
        int n;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (n == hold_at) scl_hold = 1'b1;
            if (n == hold_at + 50) scl_hold = 1'b0;
        end
        scl_hold = 1'b0;
        check_eq("rsp_valid_seen", rsp_valid, 1);
        lat = n;
        $display("cmd op=%0d data=0x%02h lat=%0d rsp_data=0x%02h nak=%0b err=%0b held=%0b",
                 op, data, lat, rsp_data, rsp_nak, rsp_err, bus_held);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_bus_held", bus_held, 0);
        check_eq("rst_scl_oe", scl_oe, 0);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // WRITE without START is rejected
        do_cmd(OP_WRITE, 8'h11, -1, lat);
        check_eq("err_lat", lat, 2);
        check_eq("err_flag", rsp_err, 1);
        check_eq("err_scl", scl_oe, 0);
        check_eq("err_sda", sda_oe, 0);
        @(posedge clk); #1;
        check_eq("rsp_pulse", rsp_valid, 0);

        // Addressed write
        do_cmd(OP_START, 8'h00, -1, lat);
        check_eq("start_lat", lat, 17);
        check_eq("start_err_clr", rsp_err, 0);
        check_eq("start_held", bus_held, 1);
        check_eq("park_scl", scl_oe, 1);
        do_cmd(OP_WRITE, 8'h44, -1, lat);
        check_eq("w44_nak", rsp_nak, 0);
        check_eq("w44_lat", lat, 145);
        do_cmd(OP_WRITE, 8'hA5, -1, lat);
        check_eq("wA5_nak", rsp_nak, 0);
        check_eq("wr_hold_data", rsp_data, 0);
        do_cmd(OP_STOP, 8'h00, -1, lat);
        check_eq("stop_lat", lat, 17);
        check_eq("stop_held", bus_held, 0);
        check_eq("stop_scl", scl_oe, 0);
        check_eq("stop_sda", sda_oe, 0);
        check_eq("bfm_wr_cnt", wr_cnt, 1);
        check_eq("bfm_wr_data", wr_log[0], 8'hA5);
        check_eq("bfm_op_write", s_read, 0);
        check_eq("bfm_stop", stop_flag, 1);

        // Addressed read of two bytes
        do_cmd(OP_START, 8'h00, -1, lat);
        do_cmd(OP_WRITE, 8'h45, -1, lat);
        check_eq("w45_nak", rsp_nak, 0);
        do_cmd(OP_READ_ACK, 8'h00, -1, lat);
        check_eq("rd_ack_data", rsp_data, 8'h5A);
        check_eq("rd_ack_nak", rsp_nak, 0);
        check_eq("rd_lat", lat, 145);
        do_cmd(OP_READ_NAK, 8'h00, -1, lat);
        check_eq("rd_nak_data", rsp_data, 8'hC3);
        do_cmd(OP_STOP, 8'h00, -1, lat);
        check_eq("rd_hold_data", rsp_data, 8'hC3);
        check_eq("mack_cnt", mack_cnt, 2);
        check_eq("mack0_low", mack_log[0], 0);
        check_eq("mack1_rel", mack_log[1], 1);

        // Absent slave
        do_cmd(OP_START, 8'h00, -1, lat);
        do_cmd(OP_WRITE, 8'h90, -1, lat);
        check_eq("noslave_nak", rsp_nak, 1);
        check_eq("noslave_lat", lat, 145);
        do_cmd(OP_STOP, 8'h00, -1, lat);

        // Repeated start, illegal op with bus held, STOP without bus held
        do_cmd(OP_START, 8'h00, -1, lat);
        do_cmd(OP_WRITE, 8'h44, -1, lat);
        do_cmd(OP_WRITE, 8'h01, -1, lat);
        check_eq("w01_nak", rsp_nak, 0);
        do_cmd(OP_START, 8'h00, -1, lat);
        check_eq("rs_held", bus_held, 1);
        check_eq("bfm_rep_start", rep_cnt, 1);
        do_cmd(OP_WRITE, 8'h45, -1, lat);
        do_cmd(OP_READ_NAK, 8'h00, -1, lat);
        check_eq("rs_rd_data", rsp_data, 8'h5A);
        check_eq("rs_read_op", s_read, 1);
        check_eq("rs_held2", bus_held, 1);
        do_cmd(3'd6, 8'h00, -1, lat);
        check_eq("ill_lat", lat, 2);
        check_eq("ill_err", rsp_err, 1);
        check_eq("ill_scl_park", scl_oe, 1);
        do_cmd(OP_STOP, 8'h00, -1, lat);
        check_eq("stop2_err", rsp_err, 0);
        check_eq("stop2_held", bus_held, 0);
        do_cmd(OP_STOP, 8'h00, -1, lat);
        check_eq("stop_nohold_err", rsp_err, 1);

        // Slave stretches SCL in bit slot 3 Q1 for 50 clk
        do_cmd(OP_START, 8'h00, -1, lat);
        do_cmd(OP_WRITE, 8'h44, 52, lat);
        check_eq("stretch_lat", lat, STRETCH_LAT);
        do_cmd(OP_STOP, 8'h00, -1, lat);

        // Reset mid-byte
        do_cmd(OP_START, 8'h00, -1, lat);
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_data = 8'h00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check_eq("mid_busy", busy, 1);
        check_eq("mid_ready", cmd_ready, 0);
        check_eq("mid_scl", scl_oe, 1);
        check_eq("mid_sda", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_scl", scl_oe, 0);
        check_eq("arst_sda", sda_oe, 0);
        check_eq("arst_ready", cmd_ready, 1);
        check_eq("arst_held", bus_held, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
